// File: rtl/rx_pixel_buffer.sv
// rx_pixel_buffer
//
// First-word-fall-through pixel buffer that sits between the radio pixel
// de-packetiser and the HDMI timing generator on the receive side.
//
// The buffer waits for the first start-of-frame pixel and discards anything
// before it. It then prefills to PREFILL entries before serving pixels. The
// head pixel is always presented on Mem_Data, and Mem_Read pops it. If a read
// arrives while the buffer is empty, the buffer flushes itself and re-aligns
// to the next frame.
//
// Ports
//   clk               pixel clock
//   rstn              asynchronous active-low reset
//   In_Valid          input pixel strobe
//   In_Data[23:0]     RGB pixel {R,G,B}
//   In_SOF            pixel is the first of a frame (qualifies In_Valid)
//   In_Field          field parity of the frame, meaningful with In_SOF
//   In_Ready          not full; a write happens on In_Valid && In_Ready
//   Mem_Read          pop request from the timing generator
//   Mem_Data[23:0]    head pixel, 0 unless running and non-empty
//   FraimSync         field parity of the frame currently at the head
//   Deb_Level[AW:0]   occupancy
//   Deb_Underflow_cnt saturating underflow event count
//   Deb_Overflow_cnt  saturating dropped-write count
//   Deb_State[1:0]    0 = WAIT_SOF, 1 = FILL, 2 = RUN
module rx_pixel_buffer #(
    parameter int AW      = 10,
    parameter int PREFILL = 640
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          In_Valid,
    input  logic [23:0]   In_Data,
    input  logic          In_SOF,
    input  logic          In_Field,
    output logic          In_Ready,
    input  logic          Mem_Read,
    output logic [23:0]   Mem_Data,
    output logic          FraimSync,
    output logic [AW:0]   Deb_Level,
    output logic [15:0]   Deb_Underflow_cnt,
    output logic [15:0]   Deb_Overflow_cnt,
    output logic [1:0]    Deb_State
);

    localparam int DEPTH = 1 << AW;
    localparam logic [AW:0] PREFILL_L = (AW+1)'(PREFILL);

    typedef enum logic [1:0] {
        WAIT_SOF = 2'd0,
        FILL     = 2'd1,
        RUN      = 2'd2
    } state_t;

    state_t state, state_nxt;

    // Each entry is {SOF, Field, Data}; the tag bits are kept in their own array.
    logic [23:0] mem_data [DEPTH];
    logic [1:0]  mem_tag  [DEPTH];

    logic [AW:0] wr_ptr, rd_ptr, level;
    logic [AW:0] wr_nxt, rd_nxt;
    logic        full, empty;
    logic        store, pop, underflow;
    logic        head_change;
    logic [1:0]  head_tag;

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    assign level    = wr_ptr - rd_ptr;
    assign empty    = (wr_ptr == rd_ptr);
    assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign In_Ready = !full;

    // FSM: state register
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state <= WAIT_SOF;
        end else begin
            state <= state_nxt;
        end
    end

    // FSM: next state
    always_comb begin
        state_nxt = state;
        unique case (state)
            WAIT_SOF: if (store)                 state_nxt = FILL;
            FILL:     if (level >= PREFILL_L)    state_nxt = RUN;
            RUN:      if (underflow)             state_nxt = WAIT_SOF;
            default:                             state_nxt = WAIT_SOF;
        endcase
    end

    // FSM: per-state write/pop/underflow decisions
    always_comb begin
        store     = 1'b0;
        pop       = 1'b0;
        underflow = 1'b0;
        unique case (state)
            WAIT_SOF: store = In_Valid && In_Ready && In_SOF;
            FILL:     store = In_Valid && In_Ready;
            RUN: begin
                underflow = Mem_Read && empty;
                pop       = Mem_Read && !empty;
                // A write in the underflow cycle is lost with the flush.
                store     = In_Valid && In_Ready && !underflow;
            end
            default: ;
        endcase
    end

    // Head tracking: the head moves when it is popped, or when a write lands
    // in an empty buffer. The new head is the word being written if the next
    // read pointer lands on the current write slot.
    assign wr_nxt      = wr_ptr + {{AW{1'b0}}, store};
    assign rd_nxt      = rd_ptr + {{AW{1'b0}}, pop};
    assign head_change = !underflow && (pop || (empty && store)) && (rd_nxt != wr_nxt);
    assign head_tag    = (store && (rd_nxt == wr_ptr)) ? {In_SOF, In_Field}
                                                       : mem_tag[rd_nxt[AW-1:0]];

    // Storage is not reset; stale contents are unreachable once the pointers clear.
    always_ff @(posedge clk) begin
        if (store) begin
            mem_data[wr_ptr[AW-1:0]] <= In_Data;
            mem_tag[wr_ptr[AW-1:0]]  <= {In_SOF, In_Field};
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr            <= '0;
            rd_ptr            <= '0;
            FraimSync         <= 1'b0;
            Deb_Underflow_cnt <= 16'd0;
            Deb_Overflow_cnt  <= 16'd0;
        end else begin
            if (underflow) begin
                wr_ptr            <= '0;
                rd_ptr            <= '0;
                Deb_Underflow_cnt <= sat_inc(Deb_Underflow_cnt);
            end else begin
                wr_ptr <= wr_nxt;
                rd_ptr <= rd_nxt;
            end
            if (In_Valid && !In_Ready) begin
                Deb_Overflow_cnt <= sat_inc(Deb_Overflow_cnt);
            end
            if (head_change && head_tag[1]) begin
                FraimSync <= head_tag[0];
            end
        end
    end

    assign Mem_Data  = (state == RUN && !empty) ? mem_data[rd_ptr[AW-1:0]] : 24'd0;
    assign Deb_Level = level;
    assign Deb_State = state;

endmodule
